// File: rtl/fetch_sequencer_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
package fetch_sequencer_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HALT  = 2'd1,
        ST_FAULT = 2'd2
    } fetch_state_t;

    localparam logic [31:0] NOP_WORD          = 32'h0000_0013;
    localparam logic [31:0] HALT_WORD_DEFAULT = 32'h0000_0063;
    localparam int unsigned INST_BYTES        = 4;

endpackage

// File: rtl/fetch_sequencer_pc_bound_check.sv
// Combinational legality check for a fetch address: word aligned and the
// whole word inside instruction memory.
module pc_bound_check (
    input  logic [63:0] addr,
    input  logic [63:0] limit,
    output logic        legal
);

    // 65-bit sum so addresses near 2^64 cannot wrap into the legal range
    logic [64:0] last_byte;

    assign last_byte = {1'b0, addr} + 65'd3;
    assign legal     = (addr[1:0] == 2'b00) && (last_byte < {1'b0, limit});

endmodule

// File: rtl/fetch_sequencer.sv
// PC and fetch controller: drives Instruction_Memory, registers the returned
// word and its PC into one output stage, and handles stall/redirect/halt/fault.
//
//   state    | meaning
//   ST_RUN   | fetching sequentially, honouring stall and redirect
//   ST_HALT  | halt word delivered, waiting for a redirect to resume
//   ST_FAULT | illegal PC seen; sticky until reset
module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter logic [63:0] RESET_PC   = 64'd0,
    parameter int unsigned IMEM_BYTES = 665,
    parameter logic [31:0] HALT_WORD  = HALT_WORD_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        Stall,
    input  logic        Redirect_Valid,
    input  logic [63:0] Redirect_Target,
    input  logic [31:0] Instruction,
    output logic [63:0] Inst_Address,
    output logic        Fetch_Valid,
    output logic [63:0] Fetch_PC,
    output logic [31:0] Fetch_Instruction,
    output logic [31:0] Fetch_Count,
    output logic        Halted,
    output logic        Fault
);

    localparam logic [63:0] LIMIT = 64'(IMEM_BYTES);

    fetch_state_t state, state_nxt;
    logic [63:0]  pc, pc_nxt;
    logic         valid_nxt;
    logic [63:0]  fetch_pc_nxt;
    logic [31:0]  fetch_inst_nxt;
    logic [31:0]  count_nxt;
    logic         redirect_legal;
    logic         pc_legal;

    pc_bound_check u_redirect_check (
        .addr  (Redirect_Target),
        .limit (LIMIT),
        .legal (redirect_legal)
    );

    pc_bound_check u_seq_check (
        .addr  (pc),
        .limit (LIMIT),
        .legal (pc_legal)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state             <= ST_RUN;
            pc                <= RESET_PC;
            Fetch_Valid       <= 1'b0;
            Fetch_PC          <= 64'd0;
            Fetch_Instruction <= NOP_WORD;
            Fetch_Count       <= 32'd0;
        end else begin
            state             <= state_nxt;
            pc                <= pc_nxt;
            Fetch_Valid       <= valid_nxt;
            Fetch_PC          <= fetch_pc_nxt;
            Fetch_Instruction <= fetch_inst_nxt;
            Fetch_Count       <= count_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        pc_nxt         = pc;
        valid_nxt      = Fetch_Valid;
        fetch_pc_nxt   = Fetch_PC;
        fetch_inst_nxt = Fetch_Instruction;
        count_nxt      = Fetch_Count;
        unique case (state)
            ST_RUN: begin
                if (Redirect_Valid) begin
                    valid_nxt = 1'b0;
                    if (redirect_legal) pc_nxt = Redirect_Target;
                    else                state_nxt = ST_FAULT;
                end else if (Stall) begin
                    valid_nxt = Fetch_Valid;
                end else if (!pc_legal) begin
                    state_nxt = ST_FAULT;
                    valid_nxt = 1'b0;
                end else begin
                    fetch_pc_nxt   = pc;
                    fetch_inst_nxt = Instruction;
                    valid_nxt      = 1'b1;
                    count_nxt      = Fetch_Count + 32'd1;
                    // The halt word is delivered but the PC parks on it
                    if (Instruction == HALT_WORD) state_nxt = ST_HALT;
                    else                          pc_nxt = pc + 64'(INST_BYTES);
                end
            end
            ST_HALT: begin
                valid_nxt = 1'b0;
                if (Redirect_Valid) begin
                    if (redirect_legal) begin
                        state_nxt = ST_RUN;
                        pc_nxt    = Redirect_Target;
                    end else begin
                        state_nxt = ST_FAULT;
                    end
                end
            end
            ST_FAULT: begin
                valid_nxt = 1'b0;
            end
            default: begin
                state_nxt = ST_FAULT;
                valid_nxt = 1'b0;
            end
        endcase
    end

    assign Inst_Address = pc;
    assign Halted       = (state == ST_HALT) || (state == ST_FAULT);
    assign Fault        = (state == ST_FAULT);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with a byte-addressed little-endian
// instruction memory model.
module tb_fetch_sequencer;

    localparam int MEM_BYTES = 665;

    logic        clk;
    logic        reset;
    logic        Stall;
    logic        Redirect_Valid;
    logic [63:0] Redirect_Target;
    logic [31:0] Instruction;
    logic [63:0] Inst_Address;
    logic        Fetch_Valid;
    logic [63:0] Fetch_PC;
    logic [31:0] Fetch_Instruction;
    logic [31:0] Fetch_Count;
    logic        Halted;
    logic        Fault;

    logic [7:0] mem [0:MEM_BYTES-1];
    int n_total;
    int n_bad;

    fetch_sequencer dut (
        .clk               (clk),
        .reset             (reset),
        .Stall             (Stall),
        .Redirect_Valid    (Redirect_Valid),
        .Redirect_Target   (Redirect_Target),
        .Instruction       (Instruction),
        .Inst_Address      (Inst_Address),
        .Fetch_Valid       (Fetch_Valid),
        .Fetch_PC          (Fetch_PC),
        .Fetch_Instruction (Fetch_Instruction),
        .Fetch_Count       (Fetch_Count),
        .Halted            (Halted),
        .Fault             (Fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        Instruction = 32'd0;
        if (Inst_Address < 64'(MEM_BYTES - 3)) begin
            Instruction = {mem[int'(Inst_Address) + 3], mem[int'(Inst_Address) + 2],
                           mem[int'(Inst_Address) + 1], mem[int'(Inst_Address)]};
        end
    end

    task automatic put_word(input int addr, input logic [31:0] w);
        mem[addr]     = w[7:0];
        mem[addr + 1] = w[15:8];
        mem[addr + 2] = w[23:16];
        mem[addr + 3] = w[31:24];
    endtask

    function automatic logic [31:0] fill_word(input int addr);
        return {16'hC0DE, 16'(addr)};
    endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_total = 0;
        n_bad   = 0;
        reset           = 1'b0;
        Stall           = 1'b0;
        Redirect_Valid  = 1'b0;
        Redirect_Target = 64'd0;
        for (int i = 0; i < MEM_BYTES; i++) mem[i] = 8'h00;
        for (int a = 0; a + 3 < MEM_BYTES; a += 4) put_word(a, fill_word(a));
        put_word(0,    32'h0020_0293);
        put_word(4,    32'h1050_3223);
        put_word(8'h50, 32'h04b9_0663);
        put_word(8'h9C, 32'h0000_0063);

        step();
        chk("rst_addr",  Inst_Address, 64'd0);
        chk("rst_valid", Fetch_Valid, 1'b0);
        chk("rst_pc",    Fetch_PC, 64'd0);
        chk("rst_inst",  Fetch_Instruction, 32'h0000_0013);
        chk("rst_count", Fetch_Count, 32'd0);
        chk("rst_halt",  Halted, 1'b0);
        chk("rst_fault", Fault, 1'b0);
        reset = 1'b1;

        step();
        chk("f0_valid", Fetch_Valid, 1'b1);
        chk("f0_pc",    Fetch_PC, 64'd0);
        chk("f0_inst",  Fetch_Instruction, 32'h0020_0293);
        step();
        chk("f1_pc",    Fetch_PC, 64'd4);
        chk("f1_inst",  Fetch_Instruction, 32'h1050_3223);
        chk("f1_count", Fetch_Count, 32'd2);
        chk("f1_addr",  Inst_Address, 64'd8);

        Stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_addr",  Inst_Address, 64'd8);
            chk("stall_pc",    Fetch_PC, 64'd4);
            chk("stall_count", Fetch_Count, 32'd2);
        end
        Stall = 1'b0;
        step();
        chk("unstall_pc",   Fetch_PC, 64'd8);
        chk("unstall_inst", Fetch_Instruction, fill_word(8));
        chk("unstall_cnt",  Fetch_Count, 32'd3);

        Stall = 1'b1;
        Redirect_Valid  = 1'b1;
        Redirect_Target = 64'h50;
        step();
        Stall = 1'b0;
        Redirect_Valid = 1'b0;
        chk("redir_bubble", Fetch_Valid, 1'b0);
        chk("redir_addr",   Inst_Address, 64'h50);
        chk("redir_count",  Fetch_Count, 32'd3);
        step();
        chk("redir_valid", Fetch_Valid, 1'b1);
        chk("redir_pc",    Fetch_PC, 64'h50);
        chk("redir_inst",  Fetch_Instruction, 32'h04b9_0663);

        // 0x54 .. 0x98 are ordinary words
        for (int i = 0; i < 18; i++) step();
        chk("pre_halt_pc", Fetch_PC, 64'h98);
        step();
        chk("halt_valid", Fetch_Valid, 1'b1);
        chk("halt_pc",    Fetch_PC, 64'h9C);
        chk("halt_inst",  Fetch_Instruction, 32'h0000_0063);
        chk("halt_count", Fetch_Count, 32'd23);
        step();
        chk("halted",       Halted, 1'b1);
        chk("halted_valid", Fetch_Valid, 1'b0);
        chk("halted_fault", Fault, 1'b0);
        chk("halted_addr",  Inst_Address, 64'h9C);

        Redirect_Valid  = 1'b1;
        Redirect_Target = 64'd0;
        step();
        Redirect_Valid = 1'b0;
        chk("resume_halt",  Halted, 1'b0);
        chk("resume_valid", Fetch_Valid, 1'b0);
        step();
        chk("resume_pc",    Fetch_PC, 64'd0);
        chk("resume_inst",  Fetch_Instruction, 32'h0020_0293);
        chk("resume_count", Fetch_Count, 32'd24);

        Redirect_Valid  = 1'b1;
        Redirect_Target = 64'h28C;
        step();
        Redirect_Valid = 1'b0;
        step();
        step();
        step();
        chk("end_pc",    Fetch_PC, 64'd660);
        chk("end_valid", Fetch_Valid, 1'b1);
        chk("end_inst",  Fetch_Instruction, fill_word(660));
        step();
        chk("oob_fault", Fault, 1'b1);
        chk("oob_halt",  Halted, 1'b1);
        chk("oob_valid", Fetch_Valid, 1'b0);
        chk("oob_addr",  Inst_Address, 64'd664);
        chk("oob_count", Fetch_Count, 32'd27);

        Redirect_Valid  = 1'b1;
        Redirect_Target = 64'd0;
        step();
        Redirect_Valid = 1'b0;
        chk("sticky_fault", Fault, 1'b1);
        chk("sticky_addr",  Inst_Address, 64'd664);

        reset = 1'b0;
        #1;
        chk("arst_addr",  Inst_Address, 64'd0);
        chk("arst_fault", Fault, 1'b0);
        chk("arst_halt",  Halted, 1'b0);
        chk("arst_count", Fetch_Count, 32'd0);
        #1;
        reset = 1'b1;
        step();
        chk("restart_pc",    Fetch_PC, 64'd0);
        chk("restart_valid", Fetch_Valid, 1'b1);

        Redirect_Valid  = 1'b1;
        Redirect_Target = 64'h52;
        step();
        chk("mis_fault", Fault, 1'b1);
        chk("mis_halt",  Halted, 1'b1);
        chk("mis_valid", Fetch_Valid, 1'b0);
        chk("mis_addr",  Inst_Address, 64'd4);
        Redirect_Target = 64'h10;
        step();
        Redirect_Valid = 1'b0;
        chk("mis_ignore", Inst_Address, 64'd4);
        chk("mis_sticky", Fault, 1'b1);

        reset = 1'b0;
        step();
        reset = 1'b1;
        Redirect_Valid  = 1'b1;
        Redirect_Target = 64'h298;
        step();
        Redirect_Valid = 1'b0;
        chk("range_fault", Fault, 1'b1);
        chk("range_valid", Fetch_Valid, 1'b0);
        chk("range_addr",  Inst_Address, 64'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
